// File: rtl/axi_wr_fifo_sink.sv
// axi_wr_fifo_sink: range-checks write beats from the AXI write subordinate,
// buffers in-range beats in a DEPTH-entry FIFO and drains them to a
// valid/ready register-bus request port.
// Optional feature macro: CALIPTRA_AXI_WR_FIFO_SINK_BYP_EN (zero-latency bypass when empty).
module axi_wr_fifo_sink #(
    parameter int unsigned     AW         = 32,
    parameter int unsigned     DW         = 32,
    parameter int unsigned     BC         = DW / 8,
    parameter int unsigned     UW         = 32,
    parameter int unsigned     IW         = 1,
    parameter int unsigned     DEPTH      = 4,
    parameter logic [AW-1:0]   BASE_ADDR  = 32'h0,
    parameter logic [AW-1:0]   LIMIT_ADDR = 32'hFFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dv,
    input  logic [AW-1:0] addr,
    input  logic [UW-1:0] user,
    input  logic [IW-1:0] id,
    input  logic [DW-1:0] wdata,
    input  logic [BC-1:0] wstrb,
    input  logic [2:0]    wsize,
    input  logic          last,
    output logic          hld,
    output logic          err,
    output logic          req_valid,
    input  logic          req_ready,
    output logic [AW-1:0] req_addr,
    output logic [UW-1:0] req_user,
    output logic [IW-1:0] req_id,
    output logic [DW-1:0] req_wdata,
    output logic [BC-1:0] req_wstrb,
    output logic [2:0]    req_wsize,
    output logic          req_last,
    output logic [7:0]    err_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [UW-1:0] user;
        logic [IW-1:0] id;
        logic [DW-1:0] wdata;
        logic [BC-1:0] wstrb;
        logic [2:0]    wsize;
        logic          last;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    entry_t in_entry;
    entry_t head;
    logic   lo_ok, hi_ok, in_range;
    logic   fifo_valid, accept, push, pop, byp_done, err_beat;

    // Skip bound compares that are trivially true so no constant comparison is built.
    if (BASE_ADDR == '0) begin : g_lo_any
        assign lo_ok = 1'b1;
    end else begin : g_lo_cmp
        assign lo_ok = (addr >= BASE_ADDR);
    end
    if (LIMIT_ADDR == '1) begin : g_hi_any
        assign hi_ok = 1'b1;
    end else begin : g_hi_cmp
        assign hi_ok = (addr <= LIMIT_ADDR);
    end

    assign in_range   = lo_ok && hi_ok;
    assign err        = dv && !in_range;
    // Backpressure decoded purely from state; no path from req_ready.
    assign hld        = (count_q == FullCnt);
    assign fifo_valid = (count_q != '0);
    assign accept     = dv && !hld;
    assign err_beat   = accept && !in_range;
    assign pop        = fifo_valid && req_ready;
    assign push       = accept && in_range && !byp_done;

    assign in_entry = '{addr: addr, user: user, id: id, wdata: wdata, wstrb: wstrb,
                        wsize: wsize, last: last};

    // Select the head entry and request valid (optionally bypassing an empty FIFO).
    always_comb begin
        head      = mem_q[rd_ptr_q];
        req_valid = fifo_valid;
        byp_done  = 1'b0;
`ifdef CALIPTRA_AXI_WR_FIFO_SINK_BYP_EN
        if (!fifo_valid) begin
            head      = in_entry;
            req_valid = dv && in_range;
            byp_done  = dv && in_range && req_ready;
        end
`endif
    end

    assign req_addr  = head.addr;
    assign req_user  = head.user;
    assign req_id    = head.id;
    assign req_wdata = head.wdata;
    assign req_wstrb = head.wstrb;
    assign req_wsize = head.wsize;
    assign req_last  = head.last;
    assign err_cnt   = err_cnt_q;

    // Next-state for pointers, occupancy and the saturating error counter.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (err_beat && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage; cleared on reset so the req_* data outputs read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

endmodule

// File: tb/tb_axi_wr_fifo_sink.sv
// Directed self-checking bench for axi_wr_fifo_sink (DEPTH=4, window 0x0..0xFFF).
module tb_axi_wr_fifo_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dv = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] user = '0;
    logic [0:0]  id = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [2:0]  wsize = '0;
    logic        last = 1'b0;
    logic        req_ready = 1'b0;
    logic        hld, err, req_valid, req_last;
    logic [31:0] req_addr, req_user, req_wdata;
    logic [0:0]  req_id;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_wsize;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad = 0;

    axi_wr_fifo_sink dut (
        .clk       (clk),
        .rst       (rst),
        .dv        (dv),
        .addr      (addr),
        .user      (user),
        .id        (id),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wsize     (wsize),
        .last      (last),
        .hld       (hld),
        .err       (err),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_user  (req_user),
        .req_id    (req_id),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_wsize (req_wsize),
        .req_last  (req_last),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic l);
        dv    = 1'b1;
        addr  = a;
        wdata = d;
        wstrb = 4'hF;
        last  = l;
    endtask

    initial begin
        // Reset
        #1 rst = 1'b1;
        step();
        step();
        chk("rst_hld", hld, 0);
        chk("rst_valid", req_valid, 0);
        chk("rst_errcnt", err_cnt, 0);
        chk("rst_addr", req_addr, 0);
        chk("rst_wdata", req_wdata, 0);
        rst = 1'b0;
        step();

        // Single beat
        req_ready = 1'b1;
        user  = 32'h1234_5678;
        id    = 1'b1;
        wsize = 3'd2;
        beat(32'h10, 32'hA5A5_0001, 1'b1);
        #1;
        chk("t1_err", err, 0);
`ifdef CALIPTRA_AXI_WR_FIFO_SINK_BYP_EN
        chk("t1_byp_valid", req_valid, 1);
        chk("t1_byp_wdata", req_wdata, 32'hA5A5_0001);
        step();
        dv = 1'b0;
`else
        chk("t1_valid_n", req_valid, 0);
        step();
        dv = 1'b0;
        #1;
        chk("t1_valid", req_valid, 1);
        chk("t1_addr", req_addr, 32'h10);
        chk("t1_wdata", req_wdata, 32'hA5A5_0001);
        chk("t1_wstrb", req_wstrb, 4'hF);
        chk("t1_last", req_last, 1);
        chk("t1_user", req_user, 32'h1234_5678);
        chk("t1_id", req_id, 1);
        chk("t1_wsize", req_wsize, 3'd2);
        step();
`endif
        chk("t1_count", dut.count_q, 0);
        chk("t1_valid_end", req_valid, 0);
        id = 1'b0;

        // Fill to full, stall a fifth beat, pop one, accept the fifth
        req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(32'h20 + 32'(4 * i), 32'hD0 + 32'(i), 1'b0);
            step();
        end
        chk("t2_hld_full", hld, 1);
        beat(32'h40, 32'hD4, 1'b1);
        step();
        chk("t2_stalled_count", dut.count_q, 4);
        chk("t2_head0", req_wdata, 32'hD0);
        chk("t2_hld_still", hld, 1);
        req_ready = 1'b1;
        step();
        chk("t2_hld_drop", hld, 0);
        chk("t2_count3", dut.count_q, 3);
        chk("t2_head1", req_wdata, 32'hD1);
        req_ready = 1'b0;
        step();
        dv = 1'b0;
        chk("t2_count4", dut.count_q, 4);
        chk("t2_hld_again", hld, 1);
        req_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk("t2_drain", req_wdata, 32'hD0 + 32'(k));
            step();
        end
        chk("t2_last5", dut.count_q, 0);
        chk("t2_empty", req_valid, 0);

        // Out of range and boundaries
        req_ready = 1'b0;
        addr = 32'h1000;
        dv = 1'b0;
        #1;
        chk("t3_err_nodv", err, 0);
        beat(32'hFFC, 32'h0, 1'b0);
        #1;
        chk("t3_err_top", err, 0);
        addr = 32'h0;
        #1;
        chk("t3_err_zero", err, 0);
        addr = 32'h1000;
        #1;
        chk("t3_err_out", err, 1);
        step();
        chk("t3_errcnt1", err_cnt, 1);
        chk("t3_nopush", dut.count_q, 0);
        chk("t3_novalid", req_valid, 0);
        repeat (253) step();
        chk("t3_errcnt254", err_cnt, 8'hFE);
        repeat (46) step();
        dv = 1'b0;
        chk("t3_errcnt_sat", err_cnt, 8'hFF);
        chk("t3_nopush_end", dut.count_q, 0);

        // Mixed burst with an illegal beat 2
        beat(32'h100, 32'hB0, 1'b0);
        step();
        beat(32'h104, 32'hB1, 1'b0);
        step();
        beat(32'h2000, 32'hB2, 1'b0);
        #1;
        chk("t4_err_b2", err, 1);
        step();
        beat(32'h10C, 32'hB3, 1'b1);
        step();
        dv = 1'b0;
        chk("t4_count3", dut.count_q, 3);
        chk("t4_errcnt_sat", err_cnt, 8'hFF);
        req_ready = 1'b1;
        chk("t4_b0_data", req_wdata, 32'hB0);
        chk("t4_b0_last", req_last, 0);
        step();
        chk("t4_b1_data", req_wdata, 32'hB1);
        chk("t4_b1_last", req_last, 0);
        step();
        chk("t4_b3_data", req_wdata, 32'hB3);
        chk("t4_b3_addr", req_addr, 32'h10C);
        chk("t4_b3_last", req_last, 1);
        step();
        chk("t4_empty", req_valid, 0);

        // Simultaneous push and pop at count=2, 10 beats across pointer wraps
        req_ready = 1'b0;
        beat(32'h200, 32'hE0, 1'b0);
        step();
        beat(32'h204, 32'hE1, 1'b0);
        step();
        req_ready = 1'b1;
        for (int k = 2; k < 10; k++) begin
            beat(32'h200 + 32'(4 * k), 32'hE0 + 32'(k), k == 9);
            #1;
            chk("t5_count", dut.count_q, 2);
            chk("t5_head", req_wdata, 32'hE0 + 32'(k - 2));
            step();
        end
        dv = 1'b0;
        chk("t5_head8", req_wdata, 32'hE8);
        step();
        chk("t5_head9", req_wdata, 32'hE9);
        chk("t5_last9", req_last, 1);
        step();
        chk("t5_empty", req_valid, 0);

        // Asynchronous reset at count=3
        req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(32'h300 + 32'(4 * i), 32'hF0 + 32'(i), 1'b0);
            step();
        end
        dv = 1'b0;
        chk("t6_count3", dut.count_q, 3);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", req_valid, 0);
        chk("t6_rst_hld", hld, 0);
        chk("t6_rst_errcnt", err_cnt, 0);
        chk("t6_rst_wdata", req_wdata, 0);
        #1 rst = 1'b0;
        beat(32'h30, 32'h6000_0001, 1'b1);
        step();
        dv = 1'b0;
        chk("t6_new_valid", req_valid, 1);
        chk("t6_new_addr", req_addr, 32'h30);
        chk("t6_new_wdata", req_wdata, 32'h6000_0001);
        chk("t6_new_count", dut.count_q, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_wr_fifo_sink.md
# axi_wr_fifo_sink

Downstream consumer of the AXI write subordinate's component interface. Each accepted write beat (dv, addr, wdata, wstrb, ...) is address-checked against a fixed window. In-range beats are buffered in a DEPTH-entry FIFO and drained to a simple valid/ready register-bus request port. The block drives hld (backpressure) and err (per-beat slave error) back to the subordinate, so bursts are absorbed without stalling on a slow register target.

## Interface

Parameters:
- AW, 32, address width
- DW, 32, data width
- BC, DW/8, byte count (derived, do not override)
- UW, 32, user width
- IW, 1, ID width
- DEPTH, 4, FIFO entries; power of 2, at least 2
- BASE_ADDR, 32'h0, lowest legal byte address (inclusive)
- LIMIT_ADDR, 32'hFFF, highest legal byte address (inclusive)

Ports (one clock; reset is asynchronous and active-high):
- clk, input, 1, clock
- rst, input, 1, asynchronous active-high reset
- dv, input, 1, write beat valid
- addr, input, AW, DW-aligned byte address
- user, input, UW, request user bits
- id, input, IW, request ID
- wdata, input, DW, write data
- wstrb, input, BC, byte strobes
- wsize, input, 3, AXI size, passed through
- last, input, 1, final beat of burst
- hld, output, 1, stall; the beat is not accepted while high
- err, output, 1, slave error for the current beat
- req_valid, output, 1, head entry valid
- req_ready, input, 1, downstream accepts the head entry
- req_addr, output, AW, head address
- req_user, output, UW, head user bits
- req_id, output, IW, head ID
- req_wdata, output, DW, head data
- req_wstrb, output, BC, head strobes
- req_wsize, output, 3, head size
- req_last, output, 1, head last flag
- err_cnt, output, 8, saturating count of errored beats

## Operation

- Acceptance: a beat is accepted when dv && !hld.
- Range check:
  - in_range = (addr >= BASE_ADDR) && (addr <= LIMIT_ADDR), full AW-bit unsigned compare.
  - err = dv && !in_range, combinational, and valid in the same cycle as the acceptance.
- Push: an accepted in-range beat is written to the FIFO at wr_ptr; wr_ptr increments.
- Errored beats: accepted (consumed) but not stored, and err_cnt increments, saturating at 8'hFF.
- Pop: on req_valid && req_ready; rd_ptr increments.
- Pointers: log2(DEPTH) bits and wrap naturally.
- Occupancy: count is $clog2(DEPTH+1) bits. It is +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
- hld = (count == DEPTH), decoded from registers only; there is no combinational path from req_ready to hld.
  - When full, a pop that cycle does not release hld until the next cycle.
  - Beats are held even if they are out of range: a full FIFO stalls errored beats too.
- req_valid = (count != 0). All req_* outputs are driven from the storage entry at rd_ptr.
- Ordering: strictly FIFO, regardless of ID. last is carried through unmodified.

## Timing

- Reset:
  - Outputs: hld=0, req_valid=0, err_cnt=0.
  - State: count=0, both pointers 0, all storage entries 0, so req_* data outputs are 0.
  - Asserting rst mid-burst flushes all entries; beats already buffered are lost.
- Latency without bypass: a beat accepted in cycle N presents req_valid in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- Empty FIFO with req_ready=1: no bubble beyond the 1-cycle latency.
- Full with a pop: the pop happens in cycle N, count becomes DEPTH-1 and hld falls in cycle N+1, and the next push is in N+1.
- err: combinational from dv and addr. Upstream samples it only when dv && !hld.
- req_* outputs are stable while req_valid && !req_ready.

## Configuration

Macro CALIPTRA_AXI_WR_FIFO_SINK_BYP_EN selects the bypass path.

- Defined:
  - When count==0, req_valid = dv && in_range, and the req_* outputs are driven combinationally from the inputs.
  - If req_ready is also high, the beat completes in the same cycle and is not pushed.
  - If req_ready is low, the beat is pushed as normal.
  - Zero-cycle latency when empty.
- Not defined: no bypass path; req_* outputs come from storage only, with fixed 1-cycle latency.

## Test plan

- Reset, then a single beat: dv=1, addr=32'h10, wdata=32'hA5A5_0001, wstrb=4'hF, last=1, req_ready=1 -> err=0, req_valid=1 next cycle with identical fields (same cycle with BYP_EN), count returns to 0.
- Fill: req_ready=0, then 4 in-range beats -> hld=1 after the 4th push, and a 5th dv is stalled. Raise req_ready for one cycle -> the head pops, hld drops the following cycle, the 5th beat is accepted, and order is preserved.
- Out of range: addr=32'h1000 with dv=1 -> err=1 the same cycle, nothing pushed, err_cnt=1. 300 such beats -> err_cnt=8'hFF.
- Mixed burst, len=3 with beat 2 at an illegal address -> beats 0, 1 and 3 emerge in order, and req_last=1 only on beat 3.
- Simultaneous push and pop at count=2 -> count stays 2, and data emerges in order across a pointer wrap (10 beats through DEPTH=4).
- Assert rst while count=3 -> req_valid=0, hld=0 and err_cnt=0 immediately (asynchronously); after release, the first new beat appears at the head.
